// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - handshaked RPN stack machine; define RPN_MUL_EN for the multi-cycle multiplier
module rpn_stack_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [3:0]                 op_code,
    input  logic [WIDTH-1:0]           op_val,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       done,
    output logic [1:0]                 status,
    output logic                       carry
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(WIDTH);

    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);
    localparam logic [DW-1:0] D_FULL = DW'(DEPTH);

    localparam logic [3:0] OP_PUSH  = 4'h0;
    localparam logic [3:0] OP_POP   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_SHL   = 4'h5;
    localparam logic [3:0] OP_SHR   = 4'h6;
    localparam logic [3:0] OP_SLT   = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_NOR   = 4'hA;
    localparam logic [3:0] OP_XOR   = 4'hB;
    localparam logic [3:0] OP_SWAP  = 4'hC;
    localparam logic [3:0] OP_DUP   = 4'hD;
    localparam logic [3:0] OP_CLEAR = 4'hE;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_UNF = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_ILL = 2'b11;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_PUSH  = 3'd1;
    localparam logic [2:0] K_POP   = 3'd2;
    localparam logic [2:0] K_BIN   = 3'd3;
    localparam logic [2:0] K_SWAP  = 3'd4;
    localparam logic [2:0] K_CLEAR = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
`ifdef RPN_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    typedef logic [WIDTH-1:0] word_t;

    logic [1:0]    state_q;
    logic [3:0]    op_q;
    word_t         val_q;
    word_t         stk     [DEPTH];
    word_t         stk_nxt [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_nxt;
    logic [1:0]    status_q;
    logic          carry_q;

    word_t         opa;
    word_t         opb;
    logic [WIDTH:0] ex_sum;
    logic [2:0]    ex_kind;
    word_t         ex_val;
    logic [1:0]    ex_status;
    logic          ex_carry;
    logic          ex_mul;

    logic [2:0]    upd_kind;
    word_t         upd_val;
    logic [1:0]    upd_status;
    logic          upd_carry;
    logic          mul_last;
    logic          fin;

    // Entry 0 is the top of stack; the array shifts on push/pop.
    always_comb begin
        opa       = stk[1];
        opb       = stk[0];
        ex_sum    = '0;
        ex_kind   = K_NONE;
        ex_val    = val_q;
        ex_status = ST_OK;
        ex_carry  = 1'b0;
        ex_mul    = 1'b0;
        case (op_q)
            OP_PUSH: begin
                if (depth_q == D_FULL) ex_status = ST_OVF;
                else                   ex_kind   = K_PUSH;
            end
            OP_POP: begin
                if (depth_q < D_ONE) ex_status = ST_UNF;
                else                 ex_kind   = K_POP;
            end
            OP_DUP: begin
                if (depth_q < D_ONE)        ex_status = ST_UNF;
                else if (depth_q == D_FULL) ex_status = ST_OVF;
                else begin
                    ex_kind = K_PUSH;
                    ex_val  = stk[0];
                end
            end
            OP_SWAP: begin
                if (depth_q < D_TWO) ex_status = ST_UNF;
                else                 ex_kind   = K_SWAP;
            end
            OP_CLEAR: ex_kind = K_CLEAR;
            OP_MUL: begin
`ifdef RPN_MUL_EN
                if (depth_q < D_TWO) ex_status = ST_UNF;
                else                 ex_mul    = 1'b1;
`else
                ex_status = ST_ILL;
`endif
            end
            OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_SLT, OP_AND, OP_OR, OP_NOR, OP_XOR: begin
                if (depth_q < D_TWO) ex_status = ST_UNF;
                else begin
                    ex_kind = K_BIN;
                    case (op_q)
                        OP_ADD: begin
                            ex_sum   = {1'b0, opa} + {1'b0, opb};
                            ex_val   = ex_sum[WIDTH-1:0];
                            ex_carry = ex_sum[WIDTH];
                        end
                        OP_SUB: begin
                            ex_sum   = {1'b0, opa} - {1'b0, opb};
                            ex_val   = ex_sum[WIDTH-1:0];
                            ex_carry = ex_sum[WIDTH];
                        end
                        OP_SHL:  ex_val = opa << opb[SW-1:0];
                        OP_SHR:  ex_val = opa >> opb[SW-1:0];
                        OP_SLT:  ex_val = {{(WIDTH-1){1'b0}}, (opa < opb)};
                        OP_AND:  ex_val = opa & opb;
                        OP_OR:   ex_val = opa | opb;
                        OP_NOR:  ex_val = ~(opa | opb);
                        default: ex_val = opa ^ opb;
                    endcase
                end
            end
            default: ex_status = ST_ILL;
        endcase
    end

`ifdef RPN_MUL_EN
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_cand;
    logic [2*WIDTH-1:0] mul_sum;
    word_t              mul_plier;
    logic [SW-1:0]      mul_cnt;

    assign mul_sum  = mul_acc + (mul_plier[0] ? mul_cand : '0);
    assign mul_last = (state_q == S_MUL) && (mul_cnt == SW'(WIDTH - 1));

    // One multiplier bit per cycle; the final partial sum feeds the stack directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_acc   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_cnt   <= '0;
        end else if (state_q == S_EXEC && ex_mul) begin
            mul_acc   <= '0;
            mul_cand  <= {{WIDTH{1'b0}}, opa};
            mul_plier <= opb;
            mul_cnt   <= '0;
        end else if (state_q == S_MUL) begin
            mul_acc   <= mul_sum;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + SW'(1);
        end
    end
`else
    assign mul_last = 1'b0;
`endif

    assign fin = (state_q == S_EXEC && !ex_mul) || mul_last;

    always_comb begin
        upd_kind   = K_NONE;
        upd_val    = ex_val;
        upd_status = ex_status;
        upd_carry  = ex_carry;
        if (state_q == S_EXEC && !ex_mul) upd_kind = ex_kind;
`ifdef RPN_MUL_EN
        if (mul_last) begin
            upd_kind   = K_BIN;
            upd_val    = mul_sum[WIDTH-1:0];
            upd_status = ST_OK;
            upd_carry  = |mul_sum[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        stk_nxt   = stk;
        depth_nxt = depth_q;
        case (upd_kind)
            K_PUSH: begin
                stk_nxt[0] = upd_val;
                for (int i = 1; i < DEPTH; i++) stk_nxt[i] = stk[i-1];
                depth_nxt = depth_q + D_ONE;
            end
            K_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stk[i+1];
                depth_nxt = depth_q - D_ONE;
            end
            K_BIN: begin
                stk_nxt[0] = upd_val;
                for (int i = 1; i < DEPTH - 1; i++) stk_nxt[i] = stk[i+1];
                depth_nxt = depth_q - D_ONE;
            end
            K_SWAP: begin
                stk_nxt[0] = stk[1];
                stk_nxt[1] = stk[0];
            end
            K_CLEAR: depth_nxt = '0;
            default: ;
        endcase
    end

    // Stack, depth and status only move on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            val_q    <= '0;
            depth_q  <= '0;
            status_q <= ST_OK;
            carry_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q    <= op_code;
                        val_q   <= op_val;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef RPN_MUL_EN
                    state_q <= ex_mul ? S_MUL : S_DONE;
`else
                    state_q <= S_DONE;
`endif
                end
`ifdef RPN_MUL_EN
                S_MUL: begin
                    if (mul_last) state_q <= S_DONE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
            if (fin) begin
                stk      <= stk_nxt;
                depth_q  <= depth_nxt;
                status_q <= upd_status;
                carry_q  <= upd_carry;
            end
        end
    end

    assign op_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign status   = status_q;
    assign carry    = carry_q;
    assign depth    = depth_q;
    assign top      = (depth_q >= D_ONE) ? stk[0] : '0;
    assign next     = (depth_q >= D_TWO) ? stk[1] : '0;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb/tb_rpn_stack_engine.sv - scoreboard bench for rpn_stack_engine (default build or RPN_MUL_EN)
module tb_rpn_stack_engine;
    localparam int W     = 16;
    localparam int D     = 8;
    localparam int LAT   = 1;
    localparam int LATM  = W + 1;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_code = 4'h0;
    logic [15:0] op_val = 16'h0;
    logic [15:0] top;
    logic [15:0] next;
    logic [3:0]  depth;
    logic        done;
    logic [1:0]  status;
    logic        carry;

    rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_val(op_val), .top(top), .next(next),
        .depth(depth), .done(done), .status(status), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [15:0] n;
        logic [3:0]  d;
        logic [1:0]  s;
        logic        c;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   checks = 0;
    int   passes = 0;
    int   opn = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   run = 0;
    int   done_cnt = 0;
    int   done_snap = 0;
    bit   burst = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s (op %0d): got 0x%0h, expected 0x%0h", nm, opn, act, expv);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (op_valid && op_ready) acc_cyc = cyc;
    end

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!op_ready) run++;
        else begin
            if (burst && run != 0) chk("ready_low_cycles", 32'(run), 32'd2);
            run = 0;
        end
        if (done) begin
            done_cnt++;
            opn++;
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                em = sb.pop_front();
                chk("top",     32'(top),           32'(em.t));
                chk("next",    32'(next),          32'(em.n));
                chk("depth",   32'(depth),         32'(em.d));
                chk("status",  32'(status),        32'(em.s));
                chk("carry",   32'(carry),         32'(em.c));
                chk("latency", 32'(cyc - acc_cyc), 32'(em.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [15:0] v);
        int n;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = c;
        op_val   = v;
        n = 0;
        while (!op_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < LIMIT), 32'd1);
        @(posedge clk);
        #1;
        if (!burst) op_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] c, input logic [15:0] v, input logic [15:0] et,
                         input logic [15:0] en, input logic [3:0] ed, input logic [1:0] es,
                         input logic ec, input int el);
        exp_t e;
        e.t = et; e.n = en; e.d = ed; e.s = es; e.c = ec; e.lat = el;
        sb.push_back(e);
        issue(c, v);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !op_ready) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_top",   32'(top),      32'd0);
        chk("rst_next",  32'(next),     32'd0);
        chk("rst_depth", 32'(depth),    32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_stat",  32'(status),   32'd0);
        chk("rst_carry", 32'(carry),    32'd0);
        rst = 1'b1;

        // op, val, top, next, depth, status, carry, latency
        do_op(4'h0, 16'h0005, 16'h0005, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0003, 16'h0003, 16'h0005, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h3, 16'h0000, 16'h0002, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h3, 16'h0000, 16'h0002, 16'h0000, 4'd1, 2'b01, 1'b0, LAT);
        do_op(4'h1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0001, 16'h0001, 16'h0000, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h3, 16'h0000, 16'hFFFF, 16'h0000, 4'd1, 2'b00, 1'b1, LAT);
        do_op(4'h0, 16'h0004, 16'h0004, 16'hFFFF, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h6, 16'h0000, 16'h0FFF, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'hE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);

        for (int i = 1; i <= D; i++)
            do_op(4'h0, 16'(i), 16'(i), (i >= 2) ? 16'(i - 1) : 16'h0, 4'(i), 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0009, 16'h0008, 16'h0007, 4'd8, 2'b10, 1'b0, LAT);
        do_op(4'hD, 16'h0000, 16'h0008, 16'h0007, 4'd8, 2'b10, 1'b0, LAT);
        do_op(4'hE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);
        do_op(4'h1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b01, 1'b0, LAT);

        do_op(4'h0, 16'h0100, 16'h0100, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0101, 16'h0101, 16'h0100, 4'd2, 2'b00, 1'b0, LAT);
`ifdef RPN_MUL_EN
        do_op(4'h4, 16'h0000, 16'h0100, 16'h0000, 4'd1, 2'b00, 1'b1, LATM);
`else
        do_op(4'h4, 16'h0000, 16'h0101, 16'h0100, 4'd2, 2'b11, 1'b0, LAT);
`endif
        do_op(4'hE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);

        do_op(4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0002, 16'h0002, 16'hFFFF, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h2, 16'h0000, 16'h0001, 16'h0000, 4'd1, 2'b00, 1'b1, LAT);
        do_op(4'h0, 16'h0003, 16'h0003, 16'h0001, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h5, 16'h0000, 16'h0008, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h00F0, 16'h00F0, 16'h0008, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h8, 16'h0000, 16'h0000, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0005, 16'h0005, 16'h0000, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h7, 16'h0000, 16'h0001, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0006, 16'h0006, 16'h0001, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h9, 16'h0000, 16'h0007, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'hF0F0, 16'hF0F0, 16'h0007, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'hB, 16'h0000, 16'hF0F7, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0F00, 16'h0F00, 16'hF0F7, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'hA, 16'h0000, 16'h0008, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'hF, 16'h0000, 16'h0008, 16'h0000, 4'd1, 2'b11, 1'b0, LAT);
        do_op(4'hE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);
        wait_idle();

        // Back-to-back with op_valid held high between requests.
        burst = 1'b1;
        do_op(4'h0, 16'h1234, 16'h1234, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'hD, 16'h0000, 16'h1234, 16'h1234, 4'd2, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h00FF, 16'h00FF, 16'h1234, 4'd3, 2'b00, 1'b0, LAT);
        do_op(4'hC, 16'h0000, 16'h1234, 16'h00FF, 4'd3, 2'b00, 1'b0, LAT);
        wait_idle();
        burst = 1'b0;
        op_valid = 1'b0;

        do_op(4'hE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0002, 16'h0002, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        do_op(4'h0, 16'h0003, 16'h0003, 16'h0002, 4'd2, 2'b00, 1'b0, LAT);
        wait_idle();

        // Abort an in-flight op with reset; no done may follow.
        done_snap = done_cnt;
        issue(4'h4, 16'h0000);
`ifdef RPN_MUL_EN
        repeat (4) @(negedge clk);
`else
        repeat (1) @(negedge clk);
`endif
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(done_snap));
        chk("abort_depth",   32'(depth),    32'd0);
        chk("abort_ready",   32'(op_ready), 32'd1);
        chk("abort_top",     32'(top),      32'd0);
        chk("abort_next",    32'(next),     32'd0);

        do_op(4'h0, 16'h0007, 16'h0007, 16'h0000, 4'd1, 2'b00, 1'b0, LAT);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
